// File: rtl/uart_frame_receiver_pkg.sv
// Shared definitions for the 8N1 UART receiver: frame geometry and FSM state encoding.
// No logic, no latency, no flow control.
package uart_frame_receiver_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_frame_receiver_sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input, with a chosen reset value.
// Latency: 2 clk_in cycles; no flow control.
module uart_frame_receiver_sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/uart_frame_receiver.sv
// 8N1 UART receiver: start detection, mid-bit sampling, byte/valid/running/error reporting.
// Latency: start seen 3 clk after the line falls; byte reported at the stop-bit sample; no backpressure.
module uart_frame_receiver
  import uart_frame_receiver_pkg::*;
#(
  parameter int CLK_DIV_COUNT = 231,
  parameter int CLK_DIV_WIDTH = 8
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_running,
  output logic       rx_invalid
);

  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CLK_DIV_WIDTH-1:0] TIMER_HALF   = CLK_DIV_WIDTH'(CLK_DIV_COUNT / 2);
  localparam logic [CLK_DIV_WIDTH-1:0] TIMER_RELOAD = CLK_DIV_WIDTH'(CLK_DIV_COUNT - 1);
  localparam logic [IDX_W-1:0]         LAST_IDX     = IDX_W'(UART_DATA_BITS - 1);

  logic rxs;

  uart_frame_receiver_sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk_in   (clk_in),
    .reset    (reset),
    .async_in (rx_line),
    .sync_out (rxs)
  );

  rx_state_e                    state_q, state_d;
  logic [CLK_DIV_WIDTH-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]             bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0]    shift_q, shift_d;
  logic [7:0]                   rx_data_q, rx_data_d;
  logic                         rx_valid_q, rx_valid_d;
  logic                         rx_running_q, rx_running_d;
  logic                         rx_invalid_q, rx_invalid_d;
  logic                         tick;

  assign tick = (timer_q == '0);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    rx_running_d = rx_running_q;
    rx_invalid_d = rx_invalid_q;

    // Reloading on the tick itself keeps bit spacing at exactly CLK_DIV_COUNT cycles.
    if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
      timer_d = tick ? TIMER_RELOAD : timer_q - CLK_DIV_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d      = ST_START;
          timer_d      = TIMER_HALF;
          rx_running_d = 1'b1;
          rx_invalid_d = 1'b0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (rxs) begin
            state_d      = ST_IDLE;
            rx_running_d = 1'b0;
            rx_invalid_d = 1'b1;
          end else begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d[bit_idx_q] = rxs;
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          rx_data_d    = shift_q;
          rx_running_d = 1'b0;
          if (rxs) begin
            state_d      = ST_IDLE;
            rx_valid_d   = 1'b1;
            rx_invalid_d = 1'b0;
          end else begin
            state_d      = ST_WAIT_IDLE;
            rx_invalid_d = 1'b1;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // A held break must not look like a fresh start bit.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_running_q <= 1'b0;
      rx_invalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_running_q <= rx_running_d;
      rx_invalid_q <= rx_invalid_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_running = rx_running_q;
  assign rx_invalid = rx_invalid_q;

endmodule
